// File: rtl/step_counter_pkg.sv
// ============================================================================
// Module  : step_counter_pkg
// Purpose : Shared encodings for the step counter and its adder.
//           MODE_* values are stored in the mode register.
//           DIR_* values are carried on the up/down direction input.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package step_counter_pkg;

   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DN    = 1'b0;

   // Per-edge action chosen by the priority mux; reset is handled separately.
   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_LOAD  = 2'd1,
      ACT_COUNT = 2'd2
   } act_e;

endpackage

`default_nettype wire

// File: rtl/step_counter_step_adder.sv
// ============================================================================
// Module  : step_adder
// Purpose : Combinational WIDTH-bit adder/subtractor. It replaces the fixed +1
//           incrementer with a parametrised step.
// Ports   : a    in  WIDTH  first operand
//           b    in  WIDTH  second operand (unsigned magnitude)
//           sub  in  1      1 = a-b, 0 = a+b
//           s    out WIDTH  result modulo 2^WIDTH
//           cb   out 1      carry out (add) or borrow out (subtract)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module step_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] s,
   output logic             cb
);

   logic [WIDTH:0] ext;

   // The result is computed one bit wider. The extra MSB is the carry for an add.
   // For a subtract it is the borrow, because the zero-extended difference wraps negative.
   always_comb begin
      if (sub) begin
         ext = {1'b0, a} - {1'b0, b};
      end else begin
         ext = {1'b0, a} + {1'b0, b};
      end
   end

   assign s  = ext[WIDTH-1:0];
   assign cb = ext[WIDTH];

endmodule

`default_nettype wire

// File: rtl/step_counter.sv
// ============================================================================
// Module  : step_counter
// Purpose : Registered up/down counter with programmable step, synchronous
//           load, wrap/saturate mode register, OVF/UNF pulses and terminal count.
// Ports   : clk     in  1      rising-edge clock
//           rst_n   in  1      synchronous reset, active-low
//           en      in  1      count enable
//           up      in  1      direction (1 up, 0 down)
//           step    in  WIDTH  step magnitude
//           load    in  1      load d (overrides en)
//           d       in  WIDTH  load value
//           sat_wr  in  1      write sat_in into mode register
//           sat_in  in  1      new mode (0 wrap, 1 saturate)
//           tc_val  in  WIDTH  terminal-count compare value
//           q       out WIDTH  current count
//           ovf     out 1      pulse: up step passed all-ones
//           unf     out 1      pulse: down step passed zero
//           tc      out 1      q == tc_val (registered with q)
//           sat     out 1      current mode
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module step_counter
   import step_counter_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter logic             SAT_DEF = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic [WIDTH-1:0] step,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             sat_wr,
   input  logic             sat_in,
   input  logic [WIDTH-1:0] tc_val,
   output logic [WIDTH-1:0] q,
   output logic             ovf,
   output logic             unf,
   output logic             tc,
   output logic             sat
);

   logic [WIDTH-1:0] sum;
   logic             cb;
   act_e             act;
   logic [WIDTH-1:0] q_next;
   logic             ovf_next;
   logic             unf_next;

   step_adder #(.WIDTH(WIDTH)) u_adder (
      .a   (q),
      .b   (step),
      .sub (up == DIR_DN),
      .s   (sum),
      .cb  (cb)
   );

   // Load has priority over counting.
   always_comb begin
      if (load) begin
         act = ACT_LOAD;
      end else if (en) begin
         act = ACT_COUNT;
      end else begin
         act = ACT_HOLD;
      end
   end

   // The clamp uses the mode register as it is before this edge.
   // A mode write in the same cycle therefore takes effect from the next edge.
   always_comb begin
      q_next   = q;
      ovf_next = 1'b0;
      unf_next = 1'b0;
      case (act)
         ACT_LOAD: q_next = d;
         ACT_COUNT: begin
            if (cb) begin
               if (up == DIR_UP) begin
                  ovf_next = 1'b1;
               end else begin
                  unf_next = 1'b1;
               end
               if (sat == MODE_SAT) begin
                  q_next = (up == DIR_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
               end else begin
                  q_next = sum;
               end
            end else begin
               q_next = sum;
            end
         end
         default: q_next = q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q   <= RST_VAL;
         ovf <= 1'b0;
         unf <= 1'b0;
         tc  <= (RST_VAL == tc_val);
         sat <= SAT_DEF;
      end else begin
         q   <= q_next;
         ovf <= ovf_next;
         unf <= unf_next;
         tc  <= (q_next == tc_val);
         if (sat_wr) begin
            sat <= sat_in;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_step_counter.sv
`default_nettype none

module tb_step_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic [7:0] step = '0;
   logic       load = 1'b0;
   logic [7:0] d = '0;
   logic       sat_wr = 1'b0;
   logic       sat_in = 1'b0;
   logic [7:0] tc_val = '0;

   logic [7:0] q8;
   logic       ovf8, unf8, tc8, sat8;
   logic [3:0] q4;
   logic       ovf4, unf4, tc4, sat4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   step_counter #(.WIDTH(8), .RST_VAL(8'd0), .SAT_DEF(1'b0)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .step(step), .load(load),
      .d(d), .sat_wr(sat_wr), .sat_in(sat_in), .tc_val(tc_val),
      .q(q8), .ovf(ovf8), .unf(unf8), .tc(tc8), .sat(sat8)
   );

   step_counter #(.WIDTH(4), .RST_VAL(4'd3), .SAT_DEF(1'b1)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .step(step[3:0]), .load(load),
      .d(d[3:0]), .sat_wr(sat_wr), .sat_in(sat_in), .tc_val(tc_val[3:0]),
      .q(q4), .ovf(ovf4), .unf(unf4), .tc(tc4), .sat(sat4)
   );

   typedef struct {
      string name;
      int    q8;
      bit    o8, u8, t8, s8;
      int    q4;
      bit    o4, u4, t4, s4;
   } exp_t;

   exp_t sb[$];

   // Reference state: plain integers, one per instance.
   int m_q8 = 0;
   bit m_s8 = 0;
   int m_q4 = 3;
   bit m_s4 = 1;

   // Behavioural rule set. The sum is an unbounded integer.
   // Leaving the range [0, 2^W-1] is overflow or underflow.
   task automatic model(input int w, input int rv, input bit sd,
                        inout int mq, inout bit ms,
                        output bit o, output bit u, output bit t,
                        input bit rn, input bit e, input bit dir, input int stp,
                        input bit ld, input int dd, input bit sw, input bit si,
                        input int tv);
      int mx;
      int s;
      mx = (1 << w) - 1;
      o = 0;
      u = 0;
      if (!rn) begin
         mq = rv;
         ms = sd;
      end else begin
         if (ld) begin
            mq = dd & mx;
         end else if (e) begin
            s = dir ? mq + (stp & mx) : mq - (stp & mx);
            if (s > mx) begin
               o  = 1;
               mq = ms ? mx : s - (mx + 1);
            end else if (s < 0) begin
               u  = 1;
               mq = ms ? 0 : s + mx + 1;
            end else begin
               mq = s;
            end
         end
         if (sw) ms = si;
      end
      t = (mq == (tv & mx));
   endtask

   task automatic cyc(input string nm, input bit rn, input bit e, input bit dir,
                      input int stp, input bit ld, input int dd,
                      input bit sw, input bit si, input int tv);
      exp_t x;
      @(negedge clk);
      rst_n  = rn;
      en     = e;
      up     = dir;
      step   = stp[7:0];
      load   = ld;
      d      = dd[7:0];
      sat_wr = sw;
      sat_in = si;
      tc_val = tv[7:0];
      x.name = nm;
      model(8, 0, 1'b0, m_q8, m_s8, x.o8, x.u8, x.t8, rn, e, dir, stp, ld, dd, sw, si, tv);
      x.q8 = m_q8;
      x.s8 = m_s8;
      model(4, 3, 1'b1, m_q4, m_s4, x.o4, x.u4, x.t4, rn, e, dir, stp, ld, dd, sw, si, tv);
      x.q4 = m_q4;
      x.s4 = m_s4;
      sb.push_back(x);
   endtask

   task automatic chk(input string nm, input string fld, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s %s actual=%0d required=%0d", nm, fld, act, req);
      end
   endtask

   // Monitor: every edge presents a new output set, so one expectation is consumed per edge.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         chk(x.name, "q8",   int'(q8),   x.q8);
         chk(x.name, "ovf8", int'(ovf8), int'(x.o8));
         chk(x.name, "unf8", int'(unf8), int'(x.u8));
         chk(x.name, "tc8",  int'(tc8),  int'(x.t8));
         chk(x.name, "sat8", int'(sat8), int'(x.s8));
         chk(x.name, "q4",   int'(q4),   x.q4);
         chk(x.name, "ovf4", int'(ovf4), int'(x.o4));
         chk(x.name, "unf4", int'(unf4), int'(x.u4));
         chk(x.name, "tc4",  int'(tc4),  int'(x.t4));
         chk(x.name, "sat4", int'(sat4), int'(x.s4));
      end
   end

   initial begin
      // Reset while load and enable are also asserted.
      cyc("reset",   0, 1, 1, 1, 1, 8'h77, 0, 0, 0);
      cyc("reset2",  0, 1, 1, 1, 1, 8'h77, 0, 0, 0);
      // Wrap up.
      cyc("ld250",   1, 0, 1, 0, 1, 250, 0, 0, 0);
      cyc("wrapup",  1, 1, 1, 10, 0, 0, 0, 0, 0);
      cyc("hold",    1, 0, 1, 10, 0, 0, 0, 0, 0);
      cyc("ld245",   1, 0, 1, 0, 1, 245, 0, 0, 0);
      cyc("exact",   1, 1, 1, 10, 0, 0, 0, 0, 0);
      // Saturate.
      cyc("modesat", 1, 0, 1, 0, 0, 0, 1, 1, 0);
      cyc("ld250s",  1, 0, 1, 0, 1, 250, 0, 0, 0);
      cyc("satup",   1, 1, 1, 10, 0, 0, 0, 0, 0);
      cyc("satup2",  1, 1, 1, 10, 0, 0, 0, 0, 0);
      cyc("ld2",     1, 0, 1, 0, 1, 2, 0, 0, 0);
      cyc("satdn",   1, 1, 0, 3, 0, 0, 0, 0, 0);
      cyc("satdn2",  1, 1, 0, 3, 0, 0, 0, 0, 0);
      cyc("step0",   1, 1, 0, 0, 0, 0, 0, 0, 0);
      // Priority.
      cyc("ldwins",  1, 1, 1, 1, 1, 8'h55, 0, 0, 0);
      cyc("rstwins", 0, 1, 1, 1, 1, 8'h55, 1, 1, 0);
      // Terminal count. Clear the narrow instance's saturate mode first.
      cyc("modewr",  1, 0, 1, 0, 0, 0, 1, 0, 12);
      for (int i = 0; i < 5; i++) cyc("tc", 1, 1, 1, 4, 0, 0, 0, 0, 12);
      // A mode write during a count uses the old mode on that edge.
      cyc("ld250m",  1, 0, 1, 0, 1, 250, 0, 0, 12);
      cyc("oldmode", 1, 1, 1, 10, 0, 0, 1, 1, 12);
      cyc("newmode", 1, 1, 1, 255, 0, 0, 0, 0, 12);
      // Sweep with wrap mode on both instances. The narrow one wraps at 15.
      cyc("wrapmode", 1, 0, 1, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 64; i++) begin
         cyc("swld", 1, 0, 1, 0, 1, i, 0, 0, 0);
         cyc("swinc", 1, 1, 1, 1, 0, 0, 0, 0, 0);
      end
      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         int stp;
         int tv;
         stp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 4));
         tv  = ($urandom_range(0, 2) == 0) ? m_q8 : int'($urandom_range(0, 255));
         cyc("rand",
             ($urandom_range(0, 40) != 0),
             bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)),
             stp,
             ($urandom_range(0, 7) == 0),
             int'($urandom_range(0, 255)),
             ($urandom_range(0, 7) == 0),
             bit'($urandom_range(0, 1)),
             tv);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
